// File: rtl/commit_checker.sv
// commit_checker
//   Checking end of the difftest commit interface. Every instruction retired
//   by the writeback stage is buffered in a small FIFO. Each buffered commit is
//   compared, in order, against the golden-model commit stream, which arrives
//   over a valid/ready interface. On the first disagreement, on a FIFO
//   overflow, or when the golden side stalls for too long, the checker halts
//   in a sticky state. It keeps a latched diagnosis until reset.
//
// Parameters
//   DEPTH    commit FIFO entries (power of two, >= 4)
//   XLEN     pc / data width
//   TIMEOUT  cycles the FIFO may stay non-empty without a golden handshake
//
// Ports
//   clock, reset              clock, asynchronous active-high reset
//   wb_commit .. wb_result    retiring instruction from writeback
//   ref_valid, ref_ready      golden commit handshake
//   ref_pc .. ref_result      golden commit contents
//   stall_req                 FIFO nearly full, asks the pipeline to stall
//   state                     0 RUN, 1 MISMATCH, 2 TIMEOUT, 3 OVERFLOW
//   mismatch_pc               pc of the offending commit
//   mismatch_field            bit0 pc, bit1 inst, bit2 wen/waddr, bit3 result
//   commit_cnt                commits checked OK
//   fifo_level                current FIFO occupancy

module commit_checker #(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_commit,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [31:0]              wb_inst,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_waddr,
  input  logic [XLEN-1:0]          wb_result,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  input  logic [XLEN-1:0]          ref_pc,
  input  logic [31:0]              ref_inst,
  input  logic                     ref_wen,
  input  logic [4:0]               ref_waddr,
  input  logic [XLEN-1:0]          ref_result,
  output logic                     stall_req,
  output logic [1:0]               state,
  output logic [XLEN-1:0]          mismatch_pc,
  output logic [3:0]               mismatch_field,
  output logic [31:0]              commit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISMATCH = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_OVERFLOW = 2'd3
  } state_e;

  // Commit storage, one array per field
  logic [XLEN-1:0] memPc     [DEPTH];
  logic [31:0]     memInst   [DEPTH];
  logic            memWen    [DEPTH];
  logic [4:0]      memWaddr  [DEPTH];
  logic [XLEN-1:0] memResult [DEPTH];

  state_e          state_q,         state_d;
  logic [PW-1:0]   wrPtr_q,         wrPtr_d;
  logic [PW-1:0]   rdPtr_q,         rdPtr_d;
  logic [LW-1:0]   level_q,         level_d;
  logic [31:0]     commitCnt_q,     commitCnt_d;
  logic [TW-1:0]   toCnt_q,         toCnt_d;
  logic [XLEN-1:0] mismatchPc_q,    mismatchPc_d;
  logic [3:0]      mismatchField_q, mismatchField_d;

  logic [XLEN-1:0] headPc;
  logic [31:0]     headInst;
  logic            headWen;
  logic [4:0]      headWaddr;
  logic [XLEN-1:0] headResult;

  logic            running;
  logic            notEmpty;
  logic            full;
  logic            refReady;
  logic            handshake;
  logic            headWrites;
  logic            refWrites;
  logic [3:0]      diffField;
  logic            isMatch;
  logic            isMismatch;
  logic            pushReq;
  logic            isOverflow;
  logic            isTimeout;
  logic            haltNow;
  logic            pushEn;
  logic            popEn;

  assign headPc     = memPc[rdPtr_q];
  assign headInst   = memInst[rdPtr_q];
  assign headWen    = memWen[rdPtr_q];
  assign headWaddr  = memWaddr[rdPtr_q];
  assign headResult = memResult[rdPtr_q];

  assign running   = (state_q == ST_RUN);
  assign notEmpty  = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign refReady  = running && notEmpty;
  assign handshake = ref_valid && refReady;

  // A write to x0 has no architectural effect. It is treated exactly like
  // no write at all, so wen=1/waddr=0 on one side equals wen=0 on the other.
  assign headWrites = headWen && (headWaddr != 5'd0);
  assign refWrites  = ref_wen && (ref_waddr != 5'd0);

  // Field-by-field comparison of the FIFO head against the golden commit.
  // rd index and result only matter when both sides really write a register.
  always_comb begin
    diffField    = 4'b0000;
    diffField[0] = (headPc != ref_pc);
    diffField[1] = (headInst != ref_inst);
    diffField[2] = (headWrites != refWrites) ||
                   (headWrites && refWrites && (headWaddr != ref_waddr));
    diffField[3] = headWrites && refWrites && (headResult != ref_result);
  end

  assign isMatch    = handshake && (diffField == 4'b0000);
  assign isMismatch = handshake && (diffField != 4'b0000);
  assign pushReq    = running && wb_commit;
  assign popEn      = isMatch;
  assign isOverflow = pushReq && full && !popEn;
  assign isTimeout  = running && notEmpty && !handshake &&
                      (toCnt_q == TW'(TIMEOUT - 1));
  assign haltNow    = isMismatch || isOverflow || isTimeout;
  // The FIFO contents are frozen on the cycle that halts. This keeps the
  // buffered view consistent with the latched diagnosis.
  assign pushEn     = pushReq && !haltNow;

  // Next-state logic for the checker. The halt causes are prioritised as
  // mismatch, then overflow, then timeout. Every halt state is sticky, and
  // while halted nothing moves.
  always_comb begin
    state_d         = state_q;
    wrPtr_d         = wrPtr_q;
    rdPtr_d         = rdPtr_q;
    level_d         = level_q;
    commitCnt_d     = commitCnt_q;
    toCnt_d         = toCnt_q;
    mismatchPc_d    = mismatchPc_q;
    mismatchField_d = mismatchField_q;

    if (running) begin
      if (isMismatch) begin
        state_d         = ST_MISMATCH;
        mismatchPc_d    = headPc;
        mismatchField_d = diffField;
      end else if (isOverflow) begin
        state_d         = ST_OVERFLOW;
        mismatchPc_d    = wb_pc;
        mismatchField_d = 4'b0000;
      end else if (isTimeout) begin
        state_d         = ST_TIMEOUT;
        mismatchPc_d    = headPc;
        mismatchField_d = 4'b0000;
      end

      if (pushEn) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (popEn) begin
        rdPtr_d     = rdPtr_q + PW'(1);
        commitCnt_d = commitCnt_q + 32'd1;
      end
      case ({pushEn, popEn})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      // The watchdog only runs while something is waiting for the golden side.
      if (handshake || !notEmpty) begin
        toCnt_d = '0;
      end else begin
        toCnt_d = toCnt_q + TW'(1);
      end
    end
  end

  // Checker state registers. The asynchronous reset discards all buffered
  // commits immediately and clears the diagnosis.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_RUN;
      wrPtr_q         <= '0;
      rdPtr_q         <= '0;
      level_q         <= '0;
      commitCnt_q     <= '0;
      toCnt_q         <= '0;
      mismatchPc_q    <= '0;
      mismatchField_q <= 4'b0000;
    end else begin
      state_q         <= state_d;
      wrPtr_q         <= wrPtr_d;
      rdPtr_q         <= rdPtr_d;
      level_q         <= level_d;
      commitCnt_q     <= commitCnt_d;
      toCnt_q         <= toCnt_d;
      mismatchPc_q    <= mismatchPc_d;
      mismatchField_q <= mismatchField_d;
    end
  end

  // FIFO payload storage. It needs no reset, because the level and pointers
  // decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (pushEn) begin
      memPc[wrPtr_q]     <= wb_pc;
      memInst[wrPtr_q]   <= wb_inst;
      memWen[wrPtr_q]    <= wb_wen;
      memWaddr[wrPtr_q]  <= wb_waddr;
      memResult[wrPtr_q] <= wb_result;
    end
  end

  assign ref_ready      = refReady;
  assign stall_req      = running && (level_q >= LW'(DEPTH - 1));
  assign state          = state_q;
  assign mismatch_pc    = mismatchPc_q;
  assign mismatch_field = mismatchField_q;
  assign commit_cnt     = commitCnt_q;
  assign fifo_level     = level_q;

endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- Hardware consumer of the writeback commit stream. It buffers each retired instruction (pc, inst, rd write) in a FIFO.
- It compares each buffered commit, in order, against a golden-model commit stream delivered over a valid/ready interface.
- Sits beside the WB stage in simulation/FPGA builds and is the checking end of the difftest commit interface.
- It halts, with a latched diagnosis, on mismatch, timeout or overflow.

Parameters:
- DEPTH, 8, commit FIFO entries; power of 2, at least 4.
- XLEN, 32, data/pc width.
- TIMEOUT, 1024, max cycles FIFO may be non-empty without a ref handshake.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wb_commit  in  1  one instruction retires this cycle
- wb_pc  in  XLEN  retired pc
- wb_inst  in  32  retired instruction
- wb_wen  in  1  retired instruction writes rd
- wb_waddr  in  5  rd index
- wb_result  in  XLEN  rd write data
- ref_valid  in  1  golden commit available
- ref_ready  out  1  checker consumes golden commit this cycle
- ref_pc  in  XLEN  golden pc
- ref_inst  in  32  golden instruction
- ref_wen  in  1  golden rd write enable
- ref_waddr  in  5  golden rd index
- ref_result  in  XLEN  golden rd write data
- stall_req  out  1  FIFO nearly full; request pipeline stall
- state  out  2  0 RUN, 1 MISMATCH, 2 TIMEOUT, 3 OVERFLOW
- mismatch_pc  out  XLEN  pc of the offending DUT commit
- mismatch_field  out  4  bit0 pc, bit1 inst, bit2 wen/waddr, bit3 result
- commit_cnt  out  32  number of commits checked OK
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, immediate):
  - state=RUN, FIFO empty, fifo_level=0, commit_cnt=0.
  - mismatch_pc=0, mismatch_field=0, timeout counter=0.
  - Reset mid-operation discards all buffered commits.
- Push:
  - When wb_commit=1 and state=RUN, write {pc,inst,wen,waddr,result} at tail.
  - A push when state!=RUN is ignored.
- ref_ready:
  - Combinational: ref_ready = (state==RUN) && (fifo_level!=0).
  - Handshake = ref_valid && ref_ready.
- Compare (combinational against FIFO head, on handshake):
  - pc and inst always compared.
  - wen compared. If both wen=1, waddr is compared.
  - result is compared only if both wen=1 and waddr!=0; writes to x0 ignore result.
  - wen=1 with waddr=0 on both sides counts as equal to wen=0.
- Match: pop head; commit_cnt+1 (wraps at 2^32); timeout counter cleared.
- Mismatch:
  - Next edge: state=MISMATCH.
  - mismatch_pc=head pc; mismatch_field=bitmask of differing fields.
  - Head not popped.
- Simultaneous push and pop: level unchanged; both pointers advance; legal when full.
- Overflow: push with fifo_level==DEPTH and no pop in the same cycle -> state=OVERFLOW, mismatch_pc=wb_pc, entry dropped.
- stall_req = (fifo_level >= DEPTH-1) && state==RUN. Registered view not required; it is combinational from level.
- Timeout:
  - Counter increments each RUN cycle with fifo_level!=0 and no handshake.
  - Cleared on handshake or when empty.
  - When counter==TIMEOUT-1 and another non-handshake cycle occurs -> state=TIMEOUT, mismatch_pc=head pc, mismatch_field=0.
- Error precedence, same cycle: MISMATCH > OVERFLOW > TIMEOUT.
- All non-RUN states are sticky until reset. Outputs are held; ref_ready=0; stall_req=0.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is tracked separately to distinguish full from empty.

Optional Feature:
- Macro COMMIT_CHECKER_DPI_EN.
- Defined:
  - On every successful compare, call DPI function commit_checker_report(pc, inst, 1).
  - On entry to any halt state, call commit_checker_halt(state, mismatch_pc, mismatch_field) exactly once. This lets the C++ harness end simulation.
- Undefined: no DPI imports or calls; the module is pure synthesizable RTL with identical port behaviour.

Test Plan:
- Matched stream: 5 DUT commits pc 0x80000000..0x80000010 step 4, ref identical, ref_valid held 1 -> commit_cnt=5, state=RUN, fifo_level=0.
- Result mismatch: 3rd commit DUT result 0x12 vs ref 0x13, waddr=5 -> state=1, mismatch_pc=0x80000008, mismatch_field=4'b1000, commit_cnt=2.
- x0 write: DUT wen=1, waddr=0, result 0xdead; ref wen=0 -> match, commit_cnt increments.
- Fill/overflow, DEPTH=8, ref_valid=0:
  - After 7 pushes, stall_req=1.
  - After 8 pushes, fifo_level=8.
  - 9th push -> state=3, mismatch_pc=9th pc.
- Timeout, TIMEOUT=16: one push, ref_valid=0 -> state=2 after 16 non-handshake cycles, mismatch_pc=pushed pc. Same with ref_valid pulsed at cycle 10 -> no timeout.
- Async reset mid-run: assert reset between edges with 3 entries buffered -> fifo_level=0, state=0, commit_cnt=0 immediately, before the next clock edge.
